m_dm_stage: RTL
===============

Name: m_dm_stage

Overview:
- Memory-stage data-memory unit. It consumes the forwarded M-stage store data (RD2 after W->M forwarding) and the M-stage ALU result as the address.
- Performs word, halfword and byte loads and stores against an internal little-endian RAM.
- Models a fixed multi-cycle access latency with a stall handshake to the hazard unit.
- Flags misaligned or out-of-range accesses. The loaded value is registered toward the M/W pipeline register.

Parameters:
- DM_WORDS, 4096, RAM depth in 32-bit words. Must be a power of two; the address range is 0 to DM_WORDS*4-1.
- LATENCY, 2, number of BUSY cycles per access. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- M_Addr  in  32  byte address (ALU result)
- M_WD  in  32  store data (forwarded RD2)
- M_MemRead  in  1  load request
- M_MemWrite  in  1  store request; never asserted together with M_MemRead
- M_MemOp  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Stores use only 000, 001 and 011.
- M_PC  in  32  instruction PC, used only by the optional trace
- M_DMRD  out  32  load result, extended per M_MemOp
- M_Stall  out  1  freeze PC/F/D/E/M registers and bubble W
- M_AdEL  out  1  load address exception
- M_AdES  out  1  store address exception

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the counter to 0.
  - M_DMRD=0, M_Stall=0.
  - Every RAM word is cleared to 0.
  - Reset mid-access aborts the access. A pending store is not committed.
- Alignment and range (combinational, from current inputs):
  - Misaligned means: word with Addr[1:0]!=0, or halfword with Addr[0]!=0.
  - Out of range means Addr >= DM_WORDS*4.
  - AdEL = MemRead & (misaligned | out of range).
  - AdES = MemWrite & (misaligned | out of range).
  - M_MemOp values 101-111 count as misaligned.
  - A faulting request is treated as no request: no stall, no RAM write, M_DMRD unchanged.
- Valid request: req = (MemRead | MemWrite) & !AdEL & !AdES.
- State machine (state encoding 2-bit):
  - IDLE:
    - M_Stall = req.
    - If req: go to BUSY and load cnt=LATENCY-1.
  - BUSY:
    - M_Stall=1.
    - If cnt!=0: cnt decrements.
    - If cnt==0: perform the access at this edge and go to DONE.
  - DONE:
    - M_Stall=0 and M_DMRD holds the load result. The pipeline advances on this edge.
    - Next state is IDLE.
  - Total stall cycles per access = LATENCY+1. M_DMRD updates only at the BUSY->DONE edge, and only for loads.
- Inputs are held stable by the pipeline while M_Stall=1. The block samples the address, data and op at the access edge.
- Store byte lanes (little-endian):
  - SW writes all 4 lanes.
  - SH writes lanes {Addr[1],0} and {Addr[1],1} with WD[15:0].
  - SB writes lane Addr[1:0] with WD[7:0].
  - Other lanes are preserved.
- Load extraction:
  - Byte = word >> (8*Addr[1:0]). Half = word >> (16*Addr[1]).
  - Signed variants sign-extend to 32 bits; unsigned variants zero-extend.
- Index = Addr[log2(DM_WORDS)+1:2].
- Back-to-back accesses: the request seen in DONE is not accepted. The next instruction's request is accepted in the following IDLE cycle.

Optional Feature:
- Macro: M_DM_TRACE_EN.
- Defined: on each committed store, $display("%d@%h: *%h <= %h", $time, M_PC, word address, merged word).
  - The merged word is the full 32-bit word after lane merge.
  - Address exceptions print "AdE @%h".
- Undefined: no display statements. The RTL is fully synthesizable with identical port behaviour.

Test Plan:
- Reset then SW Addr=0x10, WD=0x12345678, LATENCY=2 -> M_Stall high for exactly 3 cycles. Then LW 0x10 -> M_DMRD=0x12345678 in DONE.
- SB Addr=0x11, WD=0xFF, then LB 0x11 -> M_DMRD=0xFFFFFFFF. LBU 0x11 -> 0x000000FF. LW 0x10 -> 0x1234FF78.
- SH Addr=0x22, WD=0x8001, then LH 0x22 -> 0xFFFF8001. LHU 0x22 -> 0x00008001. LW 0x20 -> 0x80010000.
- LW Addr=0x13 -> M_AdEL=1, M_Stall=0, M_DMRD unchanged. SH Addr=0x4001 with DM_WORDS=4096 -> M_AdES=1 and no RAM change.
- Start LW, assert reset=0 during BUSY -> M_Stall=0 and M_DMRD=0 immediately. A store aborted the same way leaves the word at 0.
- LATENCY=1, two consecutive SW then LW on different addresses -> each access stalls 2 cycles and the final LW returns the correct data.

Source files
------------

// File: rtl/m_dm_stage.sv
// m_dm_stage -- memory-stage data-memory unit.
// Word/halfword/byte loads and stores against an internal little-endian RAM.
// Each access has a fixed multi-cycle latency. A stall handshake tells the
// hazard unit to hold the pipeline while the access is in flight.
// Misaligned and out-of-range accesses raise AdEL/AdES and are otherwise
// ignored. The load result is registered toward the M/W pipeline register.
//
// Optional build macro: M_DM_TRACE_EN
//   When defined, the block prints one line per committed store and one line
//   per address exception. When undefined, the RTL contains no display
//   statements, and the ports behave the same either way.
module m_dm_stage #(
  parameter int DM_WORDS = 4096,  // RAM depth in 32-bit words, power of two
  parameter int LATENCY  = 2      // BUSY cycles per access, >= 1
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WD,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic [2:0]  M_MemOp,
  input  logic [31:0] M_PC,
  output logic [31:0] M_DMRD,
  output logic        M_Stall,
  output logic        M_AdEL,
  output logic        M_AdES
);

  localparam int AW = $clog2(DM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0]   DM_BYTES = 33'(DM_WORDS) << 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  // Access-type encodings on M_MemOp.
  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dmrd_q, dmrd_d;
  logic [31:0]   ram_q [DM_WORDS];

  logic          misaligned;
  logic          out_of_range;
  logic          addr_bad;
  logic          req;
  logic          access;
  logic          ram_we;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   ld_data;

  // ---------------------------------------------------------------------
  // Address checking and request qualification
  // ---------------------------------------------------------------------

  // Alignment rules per access size; undefined op codes always fault.
  always_comb begin
    // NOTE: a default assignment at the top of every always_comb keeps each
    // path driving the signal, so no latch is inferred.
    misaligned = 1'b0;
    case (M_MemOp)
      OP_W:         misaligned = (M_Addr[1:0] != 2'b00);
      OP_HS, OP_HU: misaligned = M_Addr[0];
      OP_BS, OP_BU: misaligned = 1'b0;
      default:      misaligned = 1'b1;
    endcase
  end

  assign out_of_range = ({1'b0, M_Addr} >= DM_BYTES);
  assign addr_bad     = misaligned | out_of_range;
  assign M_AdEL       = M_MemRead  & addr_bad;
  assign M_AdES       = M_MemWrite & addr_bad;

  // A faulting request behaves exactly like no request.
  assign req = (M_MemRead | M_MemWrite) & ~M_AdEL & ~M_AdES;

  // ---------------------------------------------------------------------
  // RAM read path, lane merge and load extraction
  // ---------------------------------------------------------------------

  assign idx     = M_Addr[AW+1:2];
  assign rd_word = ram_q[idx];

  // Merge store data into the addressed lanes; untouched lanes keep old data.
  always_comb begin
    wr_word = rd_word;
    case (M_MemOp)
      OP_HS, OP_HU: begin
        if (M_Addr[1]) wr_word[31:16] = M_WD[15:0];
        else           wr_word[15:0]  = M_WD[15:0];
      end
      OP_BS, OP_BU: begin
        case (M_Addr[1:0])
          2'd0:    wr_word[7:0]   = M_WD[7:0];
          2'd1:    wr_word[15:8]  = M_WD[7:0];
          2'd2:    wr_word[23:16] = M_WD[7:0];
          default: wr_word[31:24] = M_WD[7:0];
        endcase
      end
      default: wr_word = M_WD;
    endcase
  end

  // Pick the addressed half/byte out of the word, then sign/zero-extend.
  always_comb begin
    half_sel = M_Addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (M_Addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    case (M_MemOp)
      OP_HS:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_HU:   ld_data = {16'h0000, half_sel};
      OP_BS:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   ld_data = {24'h000000, byte_sel};
      default: ld_data = rd_word;
    endcase
  end

  // ---------------------------------------------------------------------
  // Access sequencer: IDLE -> BUSY (LATENCY cycles) -> DONE -> IDLE
  // ---------------------------------------------------------------------

  // Next-state, latency counter and load-result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmrd_d  = dmrd_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Inputs are held while stalled; the access uses them as they are now.
          access  = req;
          state_d = S_DONE;
          if (req && M_MemRead) dmrd_d = ld_data;
        end
      end
      // The request visible in DONE belongs to the finished instruction.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_we = access & M_MemWrite;

  // Sequencer state, counter and registered load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dmrd_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, whatever the order of the statements.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmrd_q  <= dmrd_d;
    end
  end

  // RAM storage: cleared as a whole by reset, one word written per access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the memory contents must read as zero after reset, so every word
      // is reset here. This rules out a plain SRAM macro without a clear port.
      for (int i = 0; i < DM_WORDS; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      ram_q[idx] <= wr_word;
    end
  end

  // Stall while a request waits in IDLE or an access is in flight. Gating with
  // reset drops the stall at once when an access is aborted.
  assign M_Stall = reset & ((state_q == S_BUSY) || ((state_q == S_IDLE) && req));
  assign M_DMRD  = dmrd_q;

`ifdef M_DM_TRACE_EN
  // Trace of committed stores and of address exceptions seen in IDLE.
  always @(posedge clk) begin
    if (reset) begin
      if (ram_we)
        $display("%d@%h: *%h <= %h", $time, M_PC, {M_Addr[31:2], 2'b00}, wr_word);
      if ((state_q == S_IDLE) && (M_AdEL || M_AdES))
        $display("AdE @%h", M_PC);
    end
  end
`else
  // The PC feeds only the trace.
  logic unused_pc;
  assign unused_pc = ^M_PC;
`endif

endmodule
